// File: rtl/bn_act_stream_if.sv
// bn_act_stream_if: coefficient-load, input-stream and output-stream signals of bn_act_stream
interface bn_act_stream_if #(
    parameter int NUM_CH     = 16,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic                         cfg_we;
    logic [CH_W-1:0]              cfg_addr;
    logic signed [COEF_WIDTH-1:0] cfg_weight;
    logic signed [DATA_WIDTH-1:0] cfg_bias;
    logic [1:0]                   act_mode;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_sof;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_sat;

    modport master (
        output cfg_we, cfg_addr, cfg_weight, cfg_bias, act_mode,
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_sat
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_weight, cfg_bias, act_mode,
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_sat
    );
endinterface

// File: rtl/bn_act_stream.sv
// bn_act_stream: streaming fused batch-norm + activation with per-channel loadable coefficients
module bn_act_stream #(
    parameter int NUM_CH     = 16,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int FRAC_BITS  = 4
) (
    input logic            clk,
    input logic            rst,
    bn_act_stream_if.slave s
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int PW   = DATA_WIDTH + COEF_WIDTH;
    localparam int SW   = PW + 1;
    localparam logic signed [SW-1:0] HALF  = SW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [SW-1:0] MAX_S = SW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] MIN_S = ~MAX_S;
    localparam logic signed [DATA_WIDTH-1:0] MAX_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_D = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam int R6_I = (6 << FRAC_BITS) < 2 ** (DATA_WIDTH - 1) - 1 ? (6 << FRAC_BITS) : 2 ** (DATA_WIDTH - 1) - 1;
    localparam logic signed [DATA_WIDTH-1:0] R6 = DATA_WIDTH'(R6_I);

    logic signed [COEF_WIDTH-1:0] weight [NUM_CH];
    logic signed [DATA_WIDTH-1:0] bias [NUM_CH];
    logic [CH_W-1:0]              ch;
    logic [CH_W-1:0]              chan;
    logic                         adv;
    logic                         acc;
    logic                         s1_valid;
    logic signed [PW-1:0]         s1_prod;
    logic signed [DATA_WIDTH-1:0] s1_bias;
    logic [CH_W-1:0]              s1_ch;
    logic [1:0]                   s1_mode;
    logic signed [SW-1:0]         rnd;
    logic signed [SW-1:0]         sum;
    logic                         hi;
    logic                         lo;
    logic signed [DATA_WIDTH-1:0] y;
    logic signed [DATA_WIDTH-1:0] act;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_sat;

    // Both stages move together; the only stall source is a held output beat.
    assign adv         = !out_valid || s.out_ready;
    assign acc         = s.in_valid && adv;
    assign chan        = s.in_sof ? '0 : ch;
    assign s.in_ready  = adv;
    assign s.out_valid = out_valid;
    assign s.out_data  = out_data;
    assign s.out_ch    = out_ch;
    assign s.out_sat   = out_sat;

    // Coefficient file: identity on reset; a write lands on the edge, so a beat in the same cycle reads the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                weight[i] <= COEF_WIDTH'(2 ** FRAC_BITS);
                bias[i]   <= '0;
            end
        end else if (s.cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (32'(s.cfg_addr) == i) begin
                    weight[i] <= s.cfg_weight;
                    bias[i]   <= s.cfg_bias;
                end
            end
        end
    end

    // Channel counter: next expected channel after the last accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ch <= '0;
        else if (acc) ch <= chan == CH_W'(NUM_CH - 1) ? '0 : chan + CH_W'(1);
    end

    // Stage 1: full-width product plus the side-band needed by stage 2; a bubble clears the valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_bias  <= '0;
            s1_ch    <= '0;
            s1_mode  <= '0;
        end else if (adv) begin
            s1_valid <= acc;
            if (acc) begin
                s1_prod <= PW'(s.in_data) * PW'(weight[chan]);
                s1_bias <= bias[chan];
                s1_ch   <= chan;
                s1_mode <= s.act_mode;
            end
        end
    end

    // Stage 2 arithmetic: round half up, add bias in a width that cannot overflow, saturate, then activate.
    always_comb begin
        rnd = (SW'(s1_prod) + HALF) >>> FRAC_BITS;
        sum = rnd + SW'(s1_bias);
        hi  = sum > MAX_S;
        lo  = sum < MIN_S;
        y   = hi ? MAX_D : lo ? MIN_D : sum[DATA_WIDTH-1:0];
        act = s1_mode == 2'd1 ? (y < 0 ? '0 : y) :
              s1_mode == 2'd2 ? (y < 0 ? '0 : y > R6 ? R6 : y) : y;
    end

    // Output register: holds its beat while stalled so data stays stable until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= act;
                out_ch   <= s1_ch;
                out_sat  <= hi || lo;
            end
        end
    end
endmodule

// File: tb/tb_bn_act_stream.sv
// tb_bn_act_stream: directed and random streams checked against a behavioural batch-norm/activation model
module tb_bn_act_stream;
    localparam int NC = 4;
    localparam int DW = 8;
    localparam int CWD = 8;
    localparam int FB = 4;

    typedef struct {int d; int c; int s; int acc;} beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bn_act_stream_if #(.NUM_CH(NC), .DATA_WIDTH(DW), .COEF_WIDTH(CWD)) bus ();
    bn_act_stream #(.NUM_CH(NC), .DATA_WIDTH(DW), .COEF_WIDTH(CWD), .FRAC_BITS(FB)) dut (
        .clk(clk),
        .rst(rst),
        .s(bus)
    );

    beat_t q[$];
    int got_d[$];
    int got_c[$];
    int got_s[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_stall = -1;
    int mw[NC];
    int mb[NC];
    int mch = 0;
    logic held = 1'b0;
    logic [7:0] hd;
    logic [1:0] hc;
    logic hs;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", n, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int u8(input logic [7:0] v);
        return int'(v);
    endfunction

    // Result of one element from plain integer arithmetic; returns the 8-bit pattern.
    function automatic int ref_y(input int x, input int w, input int b, input int m, output int sat);
        int v;
        int lim;
        lim = (6 << FB) < 127 ? (6 << FB) : 127;
        v = ((x * w + (1 << (FB - 1))) >>> FB) + b;
        sat = (v > 127 || v < -128) ? 1 : 0;
        v = v > 127 ? 127 : v < -128 ? -128 : v;
        if (m == 1 && v < 0) v = 0;
        if (m == 2) v = v < 0 ? 0 : v > lim ? lim : v;
        return v & 255;
    endfunction

    // Compare process: samples one time unit before each rising edge.
    initial begin
        int ch;
        int sat;
        int y;
        beat_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                chk("reset_out_valid", int'(bus.out_valid), 0);
                q.delete();
                held = 1'b0;
                mch = 0;
                for (int i = 0; i < NC; i++) begin
                    mw[i] = 1 << FB;
                    mb[i] = 0;
                end
            end else begin
                chk("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
                if (held) begin
                    chk("hold_valid", int'(bus.out_valid), 1);
                    chk("hold_data", u8(bus.out_data), u8(hd));
                    chk("hold_ch", int'(bus.out_ch), int'(hc));
                    chk("hold_sat", int'(bus.out_sat), int'(hs));
                end
                if (q.size() > 0 && cyc >= q[0].acc + 2 && last_stall < q[0].acc)
                    chk("latency_valid", int'(bus.out_valid), 1);
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_beat", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", u8(bus.out_data), e.d);
                        chk("out_ch", int'(bus.out_ch), e.c);
                        chk("out_sat", int'(bus.out_sat), e.s);
                    end
                    got_d.push_back(u8(bus.out_data));
                    got_c.push_back(int'(bus.out_ch));
                    got_s.push_back(int'(bus.out_sat));
                end
                if (bus.in_valid && bus.in_ready) begin
                    ch = bus.in_sof ? 0 : mch;
                    y = ref_y(int'(bus.in_data), mw[ch], mb[ch], int'(bus.act_mode), sat);
                    q.push_back('{y, ch, sat, cyc});
                    mch = (ch + 1) % NC;
                end
                if (bus.cfg_we) begin
                    mw[bus.cfg_addr] = int'(bus.cfg_weight);
                    mb[bus.cfg_addr] = int'(bus.cfg_bias);
                end
                held = bus.out_valid && !bus.out_ready;
                if (held) begin
                    last_stall = cyc;
                    hd = bus.out_data;
                    hc = bus.out_ch;
                    hs = bus.out_sat;
                end
            end
            cyc++;
        end
    end

    task automatic clr();
        got_d.delete();
        got_c.delete();
        got_s.delete();
    endtask

    task automatic beat(input logic [7:0] d, input logic sof, input logic [1:0] m);
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_sof = sof;
        bus.act_mode = m;
        #1;
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k == 100) chk("accept_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [7:0] w, input logic [7:0] b);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_weight = w;
        bus.cfg_bias = b;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || bus.out_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) chk("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic logchk(input string n, input int i, input int d, input int c, input int s);
        chk({n, "_data"}, got_d[i], d);
        chk({n, "_ch"}, got_c[i], c);
        chk({n, "_sat"}, got_s[i], s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int sat;
        int sent;
        int acc_st;
        int e1[6];
        int e2[6];
        logic [7:0] bp[8];
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_weight = '0;
        bus.cfg_bias = '0;
        bus.act_mode = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_sof = 1'b0;
        bus.out_ready = 1'b1;
        chk("pin_model_a", ref_y(24, 32, 8, 0, sat), 'h38);
        chk("pin_model_b", ref_y(127, 32, 8, 2, sat), 'h60);
        chk("pin_model_b_sat", sat, 1);
        chk("pin_model_c", ref_y(-1, 24, 0, 0, sat), 'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_data", u8(bus.out_data), 0);
        chk("rst_out_ch", int'(bus.out_ch), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        @(negedge clk);
        beat(8'h18, 1'b1, 2'd0);
        #1;
        chk("lat_after_1", int'(bus.out_valid), 0);
        @(negedge clk);
        #1;
        chk("lat_after_2", int'(bus.out_valid), 1);
        chk("lat_data", u8(bus.out_data), 'h18);
        drain();
        clr();
        beat(8'h18, 1'b1, 2'd0);
        beat(8'hE8, 1'b0, 2'd0);
        beat(8'h7F, 1'b0, 2'd0);
        drain();
        chk("id_count", got_d.size(), 3);
        logchk("id0", 0, 'h18, 0, 0);
        logchk("id1", 1, 'hE8, 1, 0);
        logchk("id2", 2, 'h7F, 2, 0);
        cfg(2'd0, 8'h20, 8'h08);
        clr();
        beat(8'h18, 1'b1, 2'd0);
        beat(8'h7F, 1'b1, 2'd0);
        beat(8'h7F, 1'b1, 2'd2);
        drain();
        logchk("wb0", 0, 'h38, 0, 0);
        logchk("wb_sat", 1, 'h7F, 0, 1);
        logchk("wb_relu6", 2, 'h60, 0, 1);
        cfg(2'd0, 8'h18, 8'h00);
        clr();
        beat(8'h01, 1'b1, 2'd0);
        beat(8'hFF, 1'b1, 2'd0);
        beat(8'hF0, 1'b1, 2'd1);
        drain();
        logchk("rnd_pos", 0, 'h02, 0, 0);
        logchk("rnd_neg", 1, 'hFF, 0, 0);
        logchk("rnd_relu", 2, 'h00, 0, 0);
        for (int c = 0; c < NC; c++) cfg(2'(c), 8'h10, 8'h00);
        for (int i = 0; i < 8; i++) bp[i] = 8'(8'h13 * (i + 1));
        clr();
        sent = 0;
        acc_st = 0;
        for (int c = 0; c < 60 && sent < 8; c++) begin
            bus.out_ready = (c >= 5);
            bus.in_valid = 1'b1;
            bus.in_data = bp[sent];
            bus.in_sof = (sent == 0);
            bus.act_mode = 2'd0;
            #1;
            if (c == 4) chk("bp_in_ready_low", int'(bus.in_ready), 0);
            if (bus.in_ready) begin
                if (c < 5) acc_st++;
                sent++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_sent", sent, 8);
        chk("bp_fill", acc_st, 2);
        drain();
        chk("bp_count", got_d.size(), 8);
        for (int i = 0; i < 8; i++) chk("bp_order", got_d[i], u8(bp[i]));
        e1 = '{0, 1, 2, 3, 0, 1};
        e2 = '{0, 1, 0, 1, 2, 3};
        clr();
        for (int i = 0; i < 6; i++) beat(8'(i + 1), i == 0, 2'd0);
        drain();
        for (int i = 0; i < 6; i++) chk("wrap_ch", got_c[i], e1[i]);
        clr();
        for (int i = 0; i < 6; i++) beat(8'(i + 1), i == 0 || i == 2, 2'd0);
        drain();
        for (int i = 0; i < 6; i++) chk("sof_ch", got_c[i], e2[i]);
        clr();
        beat(8'h10, 1'b1, 2'd0);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h10;
        bus.in_sof = 1'b0;
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 2'd1;
        bus.cfg_weight = 8'h30;
        bus.cfg_bias = 8'h10;
        #1;
        chk("cfg_same_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b0;
        beat(8'h10, 1'b1, 2'd0);
        beat(8'h10, 1'b0, 2'd0);
        drain();
        logchk("cfg_same_ch0", 0, 'h10, 0, 0);
        logchk("cfg_same_old", 1, 'h10, 1, 0);
        logchk("cfg_new_ch0", 2, 'h10, 0, 0);
        logchk("cfg_new_ch1", 3, 'h40, 1, 0);
        cfg(2'd0, 8'h20, 8'h00);
        bus.out_ready = 1'b0;
        beat(8'h11, 1'b1, 2'd0);
        beat(8'h22, 1'b0, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(bus.out_valid), 0);
        chk("async_rst_data", u8(bus.out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        clr();
        beat(8'h18, 1'b0, 2'd0);
        drain();
        chk("post_rst_count", got_d.size(), 1);
        logchk("post_rst", 0, 'h18, 0, 0);
        for (int c = 0; c < 600; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data = 8'($urandom);
            bus.in_sof = ($urandom_range(0, 9) == 0);
            bus.act_mode = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.cfg_we = ($urandom_range(0, 7) == 0);
            bus.cfg_addr = 2'($urandom);
            bus.cfg_weight = 8'($urandom);
            bus.cfg_bias = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.cfg_we = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("final_queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bn_act_stream.md
# bn_act_stream

Streaming fused batch-norm plus activation unit for the MobileNetV3 datapath. It processes one channel element per beat under a valid/ready handshake, and keeps per-channel effective weight/bias in a run-time loadable coefficient file. Each accepted element goes through a 2-stage multiply / round-add-saturate-activate pipeline with full backpressure. It sits between a convolution engine's output stream and the next layer's input buffer, and replaces frame-parallel batch-norm arrays.

## Interface
- NUM_CH, 16: channels per pixel; channel index cycles 0..NUM_CH-1.
- DATA_WIDTH, 8: signed data and bias width, fixed point with FRAC_BITS fraction bits.
- COEF_WIDTH, 8: signed weight width, FRAC_BITS fraction bits. Must satisfy COEF_WIDTH >= FRAC_BITS+2.
- FRAC_BITS, 4: fraction bits, >= 1.
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- cfg_we, in, 1: coefficient write strobe.
- cfg_addr, in, $clog2(NUM_CH): channel to write. Writes with addr >= NUM_CH are ignored.
- cfg_weight, in, COEF_WIDTH: effective weight.
- cfg_bias, in, DATA_WIDTH: effective bias.
- act_mode, in, 2: 0 none, 1 ReLU, 2 ReLU6, 3 treated as none. Sampled per beat at acceptance.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: input accept.
- in_data, in, DATA_WIDTH: signed input element.
- in_sof, in, 1: first element of a pixel stream. Forces the beat to channel 0.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accept.
- out_data, out, DATA_WIDTH: signed result.
- out_ch, out, $clog2(NUM_CH): channel index of out_data.
- out_sat, out, 1: beat was clipped by saturation (not by ReLU6).

## Operation
- Coefficient file: NUM_CH × {weight, bias} registers.
  - Reset value is identity: weight = 1<<FRAC_BITS, bias = 0.
  - cfg write takes effect on the clock edge.
  - A beat accepted in the same cycle as a write to its channel uses the old value.
- Channel counter ch:
  - Reset 0.
  - On each accepted beat (in_valid && in_ready), the beat's channel is 0 if in_sof, else ch.
  - ch then becomes (beat channel + 1), wrapping NUM_CH-1 to 0.
- Stage 1 (accept edge): register prod = in_data × weight[chan] as a full signed DATA_WIDTH+COEF_WIDTH product. Also register bias[chan], chan and act_mode.
- Stage 2 arithmetic:
  - r = (prod + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up).
  - s = r + sign-extended bias, computed in DATA_WIDTH+COEF_WIDTH+1 bits with no intermediate overflow.
- Saturation: if s > 2^(DATA_WIDTH-1)-1, y = max and out_sat = 1. If s < -2^(DATA_WIDTH-1), y = min and out_sat = 1. Otherwise y = s[DATA_WIDTH-1:0].
- Activation on y:
  - ReLU: negative values become 0.
  - ReLU6: clamp to [0, min(6<<FRAC_BITS, 2^(DATA_WIDTH-1)-1)].
  - out_sat is unaffected by activation.
- Reset mid-operation: in-flight beats are dropped, coefficients return to identity, ch returns to 0.

## Timing
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv, combinational from registered state and out_ready.
- A stall freezes both stages. A held out_data/out_ch/out_sat stays stable until accepted.
- Latency: a beat accepted at edge N presents out_valid after edge N+2 if unstalled. Throughput is 1 beat/cycle.
- Bubbles propagate. The stage-1 valid is cleared on advance when no beat is accepted.
- Reset values:
  - out_valid = 0, out_data = 0, out_ch = 0, out_sat = 0.
  - Stage-1 valid = 0.
  - in_ready = 1 (out_valid is 0).
- A cfg write during a stall is allowed and does not affect beats already in stage 1.

## Test plan
- Identity after reset (DATA_WIDTH=8, FRAC_BITS=4): stream 0x18, 0xE8, 0x7F with mode 0 → outputs 0x18, 0xE8, 0x7F; out_ch 0, 1, 2; out_sat 0; each 2 cycles after accept.
- Load ch0 w=0x20, b=0x08; input 0x18 → 0x38. Input 0x7F → 0x7F with out_sat=1. Same with mode 2 → 0x60, out_sat=1.
- Rounding with w=0x18, b=0: input 0x01 → 0x02; input 0xFF → 0xFF. Input 0xF0 with mode 1 → 0x00.
- Backpressure: hold out_ready=0 for 5 cycles while streaming 8 beats → in_ready drops after 2 beats fill the pipe, out_data is held stable, no loss or duplication, order preserved.
- Channel wrap and sof (NUM_CH=4): 6 beats give out_ch 0,1,2,3,0,1. in_sof on the 3rd beat gives 0,1,0,1,2,3. A cfg write to ch1 in the cycle a ch1 beat is accepted → that beat uses the old coefficients.
- Async reset asserted with 2 beats in flight → out_valid = 0 immediately, the beats are never emitted, and the next beat is identity on ch 0.
